// File: rtl/nco_ftw_sequencer.sv
// Tone-command sequencer: buffers (FTW, duration) commands and plays them onto NCO strobes.
// Latency: accept at end of cycle c0 -> ftw_wr_en in c0+2, phase_wr_en in c0+3..c0+2+dur.
// Backpressure: cmd_ready = !full; a pop frees a slot only from the following cycle.
//
// Ports:
//   clk, rst        single rising-edge clock, asynchronous active-low reset
//   cmd_valid/ready command handshake; cmd_ftw = tuning word, cmd_dur = phase cycles (0 = FTW only)
//   halt            synchronous abort: flush queue, return to IDLE, no done pulse
//   ftw_wr_en/ftw_out/phase_wr_en  registered NCO strobes
//   busy            FSM active or queue non-empty; done = 1-cycle pulse on natural drain
module nco_ftw_sequencer #(
    parameter int N         = 22,
    parameter int DUR_WIDTH = 16,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [N-1:0]         cmd_ftw,
    input  logic [DUR_WIDTH-1:0] cmd_dur,
    input  logic                 halt,
    output logic                 ftw_wr_en,
    output logic [N-1:0]         ftw_out,
    output logic                 phase_wr_en,
    output logic                 busy,
    output logic                 done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [N-1:0]         ftw;
        logic [DUR_WIDTH-1:0] dur;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    cmd_t                 mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
    logic [CW-1:0]        count, count_d;
    state_t               state, state_d;
    logic [DUR_WIDTH-1:0] cnt, cnt_d;

    logic                 full, empty, wr_en, pop, pop_nxt, drain;
    cmd_t                 head;
    logic [N-1:0]         head_ftw_d;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign wr_en     = cmd_valid && !full && !halt;
    assign head      = mem[rd_ptr];

    // The FSM below tracks the state visible on the outputs in the current
    // cycle. Since outputs are registers, the pop for cycle t+1 is predicted
    // from next-state values (state_d, cnt_d, count_d) and registered now.
    assign pop = (state == LOAD) ||
                 ((state == RUN) && (cnt == DUR_WIDTH'(1)) && !empty);

    always_comb begin
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        count_d  = count;
        if (halt) begin
            rd_ptr_d = wr_ptr;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr + 1'b1;
            if (pop)   rd_ptr_d = rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_d = count + 1'b1;
                2'b01:   count_d = count - 1'b1;
                default: count_d = count;
            endcase
        end
    end

    // Head after this edge: a write lands at rd_ptr_d only when it becomes
    // the sole entry, so bypass the incoming command in that case.
    always_comb begin
        head_ftw_d = mem[rd_ptr_d].ftw;
        if (wr_en && (wr_ptr == rd_ptr_d)) head_ftw_d = cmd_ftw;
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        drain   = 1'b0;
        if (halt) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (pop) begin
            cnt_d = head.dur;
            if (head.dur != '0) begin
                state_d = RUN;
            end else if (count_d != '0) begin
                state_d = LOAD;
            end else begin
                state_d = IDLE;
                drain   = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) state_d = LOAD;
                end
                RUN: begin
                    cnt_d = cnt - 1'b1;
                    if (cnt == DUR_WIDTH'(1)) begin
                        state_d = IDLE;
                        drain   = 1'b1;
                    end
                end
                // LOAD always pops, so it never reaches here.
                default: state_d = IDLE;
            endcase
        end
    end

    assign pop_nxt = (state_d == LOAD) ||
                     ((state_d == RUN) && (cnt_d == DUR_WIDTH'(1)) && (count_d != '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ftw_wr_en   <= 1'b0;
            ftw_out     <= '0;
            phase_wr_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            wr_ptr      <= wr_ptr_d;
            rd_ptr      <= rd_ptr_d;
            count       <= count_d;
            ftw_wr_en   <= pop_nxt;
            if (pop_nxt) ftw_out <= head_ftw_d;
            phase_wr_en <= (state_d == RUN);
            busy        <= (state_d != IDLE) || (count_d != '0);
            done        <= drain;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= '{ftw: cmd_ftw, dur: cmd_dur};
    end

endmodule

// File: tb/tb_nco_ftw_sequencer.sv
// Bench for nco_ftw_sequencer: vector table of short command pairs plus
// hand-written full-queue, halt and async-reset sequences. Pops are checked
// against a scoreboard of (FTW, cycle) entries; an NCO model tracks phase.
module tb_nco_ftw_sequencer;
    localparam int N     = 22;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [N-1:0]  cmd_ftw = '0;
    logic [DW-1:0] cmd_dur = '0;
    logic          halt = 1'b0;
    logic          ftw_wr_en;
    logic [N-1:0]  ftw_out;
    logic          phase_wr_en;
    logic          busy;
    logic          done;

    nco_ftw_sequencer #(.N(N), .DUR_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ftw(cmd_ftw), .cmd_dur(cmd_dur),
        .halt(halt),
        .ftw_wr_en(ftw_wr_en), .ftw_out(ftw_out),
        .phase_wr_en(phase_wr_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] ftw;
        int           cyc;
    } exp_t;

    typedef struct {
        int            n;
        logic [N-1:0]  ftw_a;
        logic [DW-1:0] dur_a;
        logic [N-1:0]  ftw_b;
        logic [DW-1:0] dur_b;
        int            b_off;
        int            first_ph;
        int            n_phase;
        int            done_off;
        logic [N-1:0]  phase_exp;
    } vec_t;

    exp_t         sb[$];
    vec_t         vecs[6];
    int           checks = 0;
    int           fails = 0;
    int           cyc = 0;
    int           phase_total = 0;
    int           done_total = 0;
    int           last_done_cyc = -1;
    int           last_ph_rise = -1;
    logic         prev_ph = 1'b0;
    logic [N-1:0] nco_phase = '0;
    logic [N-1:0] nco_ftw = '0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic expect_pop(input logic [N-1:0] ftw, input int at);
        exp_t e;
        e.ftw = ftw;
        e.cyc = at;
        sb.push_back(e);
    endtask

    // One clock: sample at the falling edge, score pops, run the NCO model.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (ftw_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ftw_wr_en", ftw_wr_en, 0);
            end else begin
                e = sb.pop_front();
                check("pop_ftw", ftw_out, e.ftw);
                check("pop_cycle", cyc, e.cyc);
            end
        end
        if (phase_wr_en === 1'b1) begin
            phase_total++;
            if (!prev_ph) last_ph_rise = cyc;
        end
        prev_ph = phase_wr_en;
        if (done === 1'b1) begin
            done_total++;
            last_done_cyc = cyc;
            if (phase_wr_en === 1'b1) check("done_with_phase", phase_wr_en, 0);
        end
        // NCO: phase advances with the old FTW at the edge that latches the new one.
        if (phase_wr_en === 1'b1) nco_phase = nco_phase + nco_ftw;
        if (ftw_wr_en === 1'b1)   nco_ftw = ftw_out;
    endtask

    initial begin
        int           c0, ph0, dn0, acc;
        logic [N-1:0] nph0, dph;

        //          n  ftw_a        dur_a   ftw_b      dur_b  b_off first n_ph done  phase
        vecs[0] = '{1, 22'h001000, 16'd5, 22'h000000, 16'd0, 0,    3,    5,   8,   22'h005000};
        vecs[1] = '{2, 22'h000100, 16'd3, 22'h000200, 16'd2, 5,    3,    5,   8,   22'h000700};
        vecs[2] = '{2, 22'h000055, 16'd0, 22'h000066, 16'd4, 3,    4,    4,   8,   22'h000198};
        vecs[3] = '{2, 22'h3FFFFF, 16'd1, 22'h000001, 16'd1, 3,    3,    2,   5,   22'h000000};
        vecs[4] = '{2, 22'h000007, 16'd0, 22'h000008, 16'd0, 3,    0,    0,   4,   22'h000000};
        vecs[5] = '{2, 22'h000ABC, 16'd2, 22'h000DEF, 16'd0, 4,    3,    2,   5,   22'h001578};

        #1 rst = 1'b0;
        tick();
        tick();
        check("rst_ftw_wr_en", ftw_wr_en, 0);
        check("rst_ftw_out", ftw_out, 0);
        check("rst_phase_wr_en", phase_wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b1;
        tick();
        tick();

        // Table: one or two commands pushed on consecutive cycles from idle.
        for (int i = 0; i < 6; i++) begin
            ph0  = phase_total;
            dn0  = done_total;
            nph0 = nco_phase;
            c0   = cyc;
            cmd_valid = 1'b1;
            cmd_ftw   = vecs[i].ftw_a;
            cmd_dur   = vecs[i].dur_a;
            expect_pop(vecs[i].ftw_a, c0 + 2);
            tick();
            if (vecs[i].n == 2) begin
                cmd_ftw = vecs[i].ftw_b;
                cmd_dur = vecs[i].dur_b;
                expect_pop(vecs[i].ftw_b, c0 + vecs[i].b_off);
                tick();
            end
            cmd_valid = 1'b0;
            repeat (16) tick();
            dph = nco_phase - nph0;
            check($sformatf("v%0d_sb_drained", i), sb.size(), 0);
            check($sformatf("v%0d_phase_cycles", i), phase_total - ph0, vecs[i].n_phase);
            if (vecs[i].n_phase > 0)
                check($sformatf("v%0d_first_phase", i), last_ph_rise - c0, vecs[i].first_ph);
            check($sformatf("v%0d_done_count", i), done_total - dn0, 1);
            check($sformatf("v%0d_done_cycle", i), last_done_cyc - c0, vecs[i].done_off);
            check($sformatf("v%0d_nco_phase", i), dph, vecs[i].phase_exp);
            check($sformatf("v%0d_busy_idle", i), busy, 0);
        end

        // Full queue: one running segment, DEPTH more queued, one extra held.
        ph0 = phase_total;
        dn0 = done_total;
        c0  = cyc;
        cmd_valid = 1'b1;
        cmd_ftw   = 22'h10;
        cmd_dur   = 16'd10;
        expect_pop(22'h10, c0 + 2);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        for (int k = 0; k < DEPTH; k++) begin
            check($sformatf("full_ready_%0d", k), cmd_ready, 1);
            cmd_valid = 1'b1;
            cmd_ftw   = 22'h11 + N'(k);
            cmd_dur   = 16'd10;
            expect_pop(22'h11 + N'(k), c0 + 12 + 10 * k);
            tick();
        end
        check("full_ready_low", cmd_ready, 0);
        cmd_ftw = 22'h15;
        cmd_dur = 16'd1;
        expect_pop(22'h15, c0 + 52);
        acc = -1;
        for (int k = 0; k < 20 && acc < 0; k++) begin
            if (cmd_ready) acc = cyc;
            tick();
        end
        cmd_valid = 1'b0;
        check("full_extra_accept_cycle", acc - c0, 13);
        for (int k = 0; k < 60 && done_total == dn0; k++) tick();
        check("full_done_count", done_total - dn0, 1);
        check("full_done_cycle", last_done_cyc - c0, 54);
        check("full_phase_cycles", phase_total - ph0, 51);
        check("full_sb_drained", sb.size(), 0);

        // Halt during the first of three queued segments; offered command dropped.
        tick();
        dn0 = done_total;
        c0  = cyc;
        cmd_valid = 1'b1;
        cmd_ftw   = 22'h21;
        cmd_dur   = 16'd8;
        expect_pop(22'h21, c0 + 2);
        tick();
        cmd_ftw = 22'h22;
        tick();
        cmd_ftw = 22'h23;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("halt_pre_phase", phase_wr_en, 1);
        halt      = 1'b1;
        cmd_valid = 1'b1;
        cmd_ftw   = 22'h99;
        cmd_dur   = 16'd3;
        tick();
        halt      = 1'b0;
        cmd_valid = 1'b0;
        check("halt_phase_wr_en", phase_wr_en, 0);
        check("halt_ftw_wr_en", ftw_wr_en, 0);
        check("halt_busy", busy, 0);
        check("halt_done", done, 0);
        check("halt_cmd_ready", cmd_ready, 1);
        repeat (20) tick();
        check("halt_no_done", done_total - dn0, 0);
        check("halt_sb_drained", sb.size(), 0);
        check("halt_busy_after", busy, 0);

        // Asynchronous reset in the middle of a segment.
        ph0 = phase_total;
        dn0 = done_total;
        c0  = cyc;
        cmd_valid = 1'b1;
        cmd_ftw   = 22'h31;
        cmd_dur   = 16'd10;
        expect_pop(22'h31, c0 + 2);
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        check("arst_pre_phase", phase_wr_en, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_ftw_wr_en", ftw_wr_en, 0);
        check("arst_ftw_out", ftw_out, 0);
        check("arst_phase_wr_en", phase_wr_en, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        tick();
        rst = 1'b1;
        repeat (15) tick();
        check("arst_phase_cycles", phase_total - ph0, 3);
        check("arst_no_done", done_total - dn0, 0);
        check("arst_sb_drained", sb.size(), 0);
        check("arst_ready_after", cmd_ready, 1);
        check("arst_busy_after", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
